fact_ctrl: RTL and testbench
============================

# fact_ctrl

Control and accumulate stage that sits directly downstream of the `cnt` up-counter in the factorial datapath. It accepts an operand `n` through a start/done handshake and drives the counter's enable, load and load-value inputs. Each cycle it multiplies a running product by the counter output, and it presents n! with a sticky overflow flag when done. It is the sequencing heart of the factorial engine; the counter is instantiated alongside it, not inside it.

## Interface
- `SIZE_`, 8, width of `n_` and of the counter bus; must match the `cnt` instance.
- `RES_W_`, 32, width of the product register and of `result_`.
- `clk_`  in  1  single clock; all state updates on the rising edge.
- `rst_n_`  in  1  reset, asynchronous and active-low.
- `start_`  in  1  request; sampled only in IDLE.
- `n_`  in  SIZE_  operand; captured on the accepting edge.
- `busy_`  out  1  high in LOAD, RUN and DONE.
- `done_`  out  1  one-cycle pulse in DONE; result valid.
- `result_`  out  RES_W_  n! truncated to RES_W_ bits; held until the next DONE.
- `ovf_`  out  1  true product exceeded RES_W_ bits; held with `result_`.
- `cnt_en_`  out  1  to counter `en_`.
- `cnt_load_`  out  1  to counter `load_cnt_`.
- `cnt_d_`  out  SIZE_  to counter `d_`; constant 1.
- `cnt_q_`  in  SIZE_  from counter `q_`.

## Operation
- States: IDLE, LOAD, RUN, DONE. The FSM is registered; counter controls are decoded combinationally from the state.
- IDLE: `cnt_en_`=0, `cnt_load_`=0. If `start_`=1: `n_reg`<=`n_`, `prod`<=1, `ovf_acc`<=0, and the FSM goes to LOAD.
- LOAD: `cnt_en_`=1, `cnt_load_`=1, `cnt_d_`=1. The counter holds 1 after the edge. The FSM goes to RUN.
- RUN: `cnt_en_`=1, `cnt_load_`=0. On each edge:
  - `prod`<=low RES_W_ bits of `prod`*`cnt_q_`.
  - `ovf_acc`<=`ovf_acc` | (upper SIZE_ bits of the full RES_W_+SIZE_ product nonzero).
  - If `cnt_q_` >= `n_reg`, the FSM goes to DONE, and `result_`/`ovf_` load the new product and flag on the same edge.
- DONE: `cnt_en_`=0, `done_`=1 for exactly one cycle, then the FSM goes to IDLE.
- n=0 and n=1 both give one RUN cycle with q=1, so the result is 1.
- `start_` outside IDLE is ignored; no queuing. A start asserted during the DONE cycle is dropped.
- The counter value after DONE is don't-care; it is reloaded on the next LOAD.
- Multiplication is unsigned, full width RES_W_+SIZE_; overflow is never cleared mid-operation.

## Timing
- Reset (asynchronous, any state): state=IDLE, `busy_`=0, `done_`=0, `result_`=0, `ovf_`=0, `cnt_en_`=0, `cnt_load_`=0. `prod` and `n_reg` are cleared to 0.
- Reset mid-RUN: the operation is abandoned, no `done_` pulse, and `result_` reads 0.
- Let m = max(n,1) and call the accepting edge edge 0.
  - LOAD occupies the cycle after edge 0.
  - RUN edges are 2..m+1.
  - `done_` is high in the cycle after edge m+1, so latency is m+1 edges.
- `busy_` rises after edge 0 and falls after edge m+2.
- Back-to-back throughput: a new start can be accepted at edge m+3 at the earliest.
- The `cnt_q_` to `prod` path is one multiply in one cycle; no pipelining at the defaults.

## Structure
- Shared package `fact_pkg`:
  - state typedef with IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3;
  - default SIZE/RES_W constants;
  - CNT_INIT=1.
- Sub-module `fact_mul`: combinational RES_W_×SIZE_ unsigned multiply. It outputs the truncated product and the overflow bit (upper bits nonzero).
- The bench instantiates `fact_ctrl` with a real `cnt` instance wired to the `cnt_*` ports.

## Test plan
- Reset held 3 cycles, then released with `start_`=0 -> all outputs 0, `busy_`=0, state IDLE indefinitely.
- `n_`=5, `start_` pulse -> `done_` 6 edges later, `result_`=120, `ovf_`=0; `busy_` high 7 cycles.
- `n_`=0, then `n_`=1 -> each gives `result_`=1, `ovf_`=0, `done_` 2 edges after accept.
- `n_`=12 -> `result_`=479001600, `ovf_`=0; `n_`=13 -> `result_`=1932053504, `ovf_`=1.
- `n_`=4 accepted; `start_`=1 with `n_`=9 held through RUN and DONE -> first `result_`=24. The next op is accepted only in IDLE; it gives 362880.
- `n_`=10; `rst_n_` pulled low at the 3rd RUN edge -> outputs immediately 0, no `done_`. After release, `n_`=3 gives 6.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial control/accumulate stage.
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_SIZE  = 8;
  localparam int DEF_RES_W = 32;
  localparam int CNT_INIT  = 1;

endpackage

// File: rtl/fact_ctrl_if.sv
// Handshake, result and counter-control bundle between fact_ctrl and its neighbours.
interface fact_ctrl_if #(
  parameter int SIZE_  = fact_pkg::DEF_SIZE,
  parameter int RES_W_ = fact_pkg::DEF_RES_W
);
  logic              start_;
  logic [SIZE_-1:0]  n_;
  logic              busy_;
  logic              done_;
  logic [RES_W_-1:0] result_;
  logic              ovf_;
  logic              cnt_en_;
  logic              cnt_load_;
  logic [SIZE_-1:0]  cnt_d_;
  logic [SIZE_-1:0]  cnt_q_;

  modport slave (
    input  start_, n_, cnt_q_,
    output busy_, done_, result_, ovf_, cnt_en_, cnt_load_, cnt_d_
  );

  modport master (
    output start_, n_, cnt_q_,
    input  busy_, done_, result_, ovf_, cnt_en_, cnt_load_, cnt_d_
  );
endinterface

// File: rtl/cnt.sv
// Loadable up-counter feeding fact_ctrl; load takes priority when enabled.
module cnt #(
  parameter int SIZE_ = fact_pkg::DEF_SIZE
) (
  input  logic             clk_,
  input  logic             rst_n_,
  input  logic             en_,
  input  logic             load_cnt_,
  input  logic [SIZE_-1:0] d_,
  output logic [SIZE_-1:0] q_
);
  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_)       q_ <= '0;
    else if (en_) begin
      if (load_cnt_)   q_ <= d_;
      else             q_ <= q_ + 1'b1;
    end
  end
endmodule

// File: rtl/fact_mul.sv
// Combinational unsigned RES_W_ x SIZE_ multiply: truncated product plus overflow flag.
module fact_mul #(
  parameter int SIZE_  = fact_pkg::DEF_SIZE,
  parameter int RES_W_ = fact_pkg::DEF_RES_W
) (
  input  logic [RES_W_-1:0] a,
  input  logic [SIZE_-1:0]  b,
  output logic [RES_W_-1:0] p,
  output logic              ovf
);
  localparam int FW = RES_W_ + SIZE_;

  logic [FW-1:0] full;

  assign full = FW'(a) * FW'(b);
  assign p    = full[RES_W_-1:0];
  assign ovf  = |full[FW-1:RES_W_];
endmodule

// File: rtl/fact_ctrl.sv
// Factorial sequencer: drives the external counter and accumulates prod *= cnt_q each RUN cycle.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int SIZE_  = DEF_SIZE,
  parameter int RES_W_ = DEF_RES_W
) (
  input  logic        clk_,
  input  logic        rst_n_,
  fact_ctrl_if.slave  bus
);
  state_t            state, state_nxt;
  logic [SIZE_-1:0]  n_reg;
  logic [RES_W_-1:0] prod;
  logic              ovf_acc;
  logic [RES_W_-1:0] result_r;
  logic              ovf_r;

  logic [RES_W_-1:0] mul_p;
  logic              mul_ovf;
  logic              last;

  fact_mul #(.SIZE_(SIZE_), .RES_W_(RES_W_)) u_mul (
    .a   (prod),
    .b   (bus.cnt_q_),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  // n=0 terminates on the first RUN cycle just like n=1, since q starts at 1.
  assign last = (bus.cnt_q_ >= n_reg);

  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) begin
      state    <= IDLE;
      n_reg    <= '0;
      prod     <= '0;
      ovf_acc  <= 1'b0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start_) begin
          n_reg   <= bus.n_;
          prod    <= RES_W_'(1);
          ovf_acc <= 1'b0;
        end
        RUN: begin
          prod    <= mul_p;
          ovf_acc <= ovf_acc | mul_ovf;
          if (last) begin
            result_r <= mul_p;
            ovf_r    <= ovf_acc | mul_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.busy_     = 1'b1;
    bus.done_     = 1'b0;
    bus.cnt_en_   = 1'b0;
    bus.cnt_load_ = 1'b0;
    case (state)
      IDLE: begin
        bus.busy_ = 1'b0;
        if (bus.start_) state_nxt = LOAD;
      end
      LOAD: begin
        bus.cnt_en_   = 1'b1;
        bus.cnt_load_ = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        bus.cnt_en_ = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.done_ = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cnt_d_  = SIZE_'(CNT_INIT);
  assign bus.result_ = result_r;
  assign bus.ovf_    = ovf_r;
endmodule

// File: tb/tb_fact_ctrl.sv
// Directed bench for fact_ctrl wired to a real cnt instance.
module tb_fact_ctrl;
  logic clk_ = 1'b0;
  logic rst_n_;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_ = ~clk_;

  fact_ctrl_if #(.SIZE_(8), .RES_W_(32)) bus ();

  fact_ctrl #(.SIZE_(8), .RES_W_(32)) dut (
    .clk_   (clk_),
    .rst_n_ (rst_n_),
    .bus    (bus)
  );

  cnt #(.SIZE_(8)) u_cnt (
    .clk_      (clk_),
    .rst_n_    (rst_n_),
    .en_       (bus.cnt_en_),
    .load_cnt_ (bus.cnt_load_),
    .d_        (bus.cnt_d_),
    .q_        (bus.cnt_q_)
  );

  typedef struct {
    logic [7:0]  n;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Waits for done after the accepting edge; returns edges taken (k) and busy cycles seen.
  task automatic wait_done(input string nm, output int k, output int busy_cnt, output bit got);
    k = 0; busy_cnt = 0; got = 0;
    while (k < 300) begin
      if (bus.busy_) busy_cnt++;
      if (bus.done_) begin got = 1; break; end
      @(negedge clk_); k++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
  endtask

  task automatic run_op(input string nm, input logic [7:0] n, input logic [31:0] er, input logic eo);
    int k, bc, m;
    bit got;
    m = (n == 0) ? 1 : int'(n);
    @(negedge clk_); bus.start_ = 1'b1; bus.n_ = n;
    @(posedge clk_);
    @(negedge clk_); bus.start_ = 1'b0;
    chk({nm, "_load_ctl"}, {bus.cnt_en_, bus.cnt_load_, bus.cnt_d_}, {2'b11, 8'd1});
    wait_done(nm, k, bc, got);
    if (got) begin
      chk({nm, "_latency"}, k, m + 1);
      chk({nm, "_result"}, bus.result_, er);
      chk({nm, "_ovf"}, bus.ovf_, eo);
      @(negedge clk_);
      chk({nm, "_busy_len"}, bc, m + 2);
      chk({nm, "_pulse_end"}, {bus.done_, bus.busy_}, 2'b00);
      chk({nm, "_held"}, {bus.ovf_, bus.result_}, {eo, er});
    end
  endtask

  initial begin
    int k, bc, seen;
    bit got;
    vecs[0] = '{n: 8'd5,  res: 32'd120,        ovf: 1'b0};
    vecs[1] = '{n: 8'd0,  res: 32'd1,          ovf: 1'b0};
    vecs[2] = '{n: 8'd1,  res: 32'd1,          ovf: 1'b0};
    vecs[3] = '{n: 8'd12, res: 32'd479001600,  ovf: 1'b0};
    vecs[4] = '{n: 8'd13, res: 32'd1932053504, ovf: 1'b1};
    vecs[5] = '{n: 8'd2,  res: 32'd2,          ovf: 1'b0};
    vecs[6] = '{n: 8'd7,  res: 32'd5040,       ovf: 1'b0};

    rst_n_ = 1'b0; bus.start_ = 1'b0; bus.n_ = '0;
    repeat (3) @(posedge clk_);
    @(negedge clk_);
    chk("in_reset", {bus.busy_, bus.done_, bus.ovf_, bus.cnt_en_, bus.cnt_load_, bus.result_},
        {5'b0, 32'd0});
    rst_n_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_);
      chk("idle_after_reset",
          {bus.busy_, bus.done_, bus.ovf_, bus.cnt_en_, bus.cnt_load_, bus.result_}, {5'b0, 32'd0});
    end

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i].n, vecs[i].res, vecs[i].ovf);

    // start held high through RUN/DONE: only re-accepted once back in IDLE
    @(negedge clk_); bus.start_ = 1'b1; bus.n_ = 8'd4;
    @(posedge clk_);
    @(negedge clk_); bus.n_ = 8'd9;
    wait_done("hold4", k, bc, got);
    if (got) begin
      chk("hold4_latency", k, 5);
      chk("hold4_result", bus.result_, 32'd24);
      @(negedge clk_);
      chk("hold_idle_gap", {bus.busy_, bus.done_}, 2'b00);
      @(posedge clk_);
      @(negedge clk_); bus.start_ = 1'b0;
      chk("hold9_accepted", {bus.busy_, bus.cnt_load_}, 2'b11);
      wait_done("hold9", k, bc, got);
      if (got) begin
        chk("hold9_latency", k, 10);
        chk("hold9_result", bus.result_, 32'd362880);
      end
    end

    // reset at the third RUN edge (edge 4) of an n=10 operation
    @(negedge clk_); bus.start_ = 1'b1; bus.n_ = 8'd10;
    @(posedge clk_);
    @(negedge clk_); bus.start_ = 1'b0;
    repeat (4) @(posedge clk_);
    #1 rst_n_ = 1'b0;
    #1 chk("midrun_reset_outs",
           {bus.busy_, bus.done_, bus.ovf_, bus.cnt_en_, bus.cnt_load_, bus.result_}, {5'b0, 32'd0});
    repeat (2) @(negedge clk_);
    rst_n_ = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_);
      if (bus.done_ || bus.busy_) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    chk("result_zero_after_reset", bus.result_, 32'd0);
    run_op("post_reset_n3", 8'd3, 32'd6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
